// File: rtl/ssp_pkg.sv
// Shared SSP constants and receive FSM state encoding; no logic, no latency.
// Used by both the receive and transmit sides, so there is no backpressure here.
package ssp_pkg;
  localparam int SSP_DATA_W     = 8;
  localparam int SSP_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ssp_rx_state_t;
endpackage

// File: rtl/ssp_rx_fifo.sv
// Show-ahead receive FIFO; a push is visible on dout/empty one cycle later.
// No backpressure: a push while full with no pop drops the byte and pulses overrun.
module ssp_rx_fifo
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int DEPTH  = SSP_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              overrun
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovr_q, ovr_d;
  logic              pop_ok, push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];
  assign overrun = ovr_q;

  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovr_d    = push && !push_ok;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end
endmodule

// File: rtl/ssp_receiver.sv
// SSP serial receiver: bits sampled on SSPCLKIN falling edges, byte in FIFO 1 PCLK after 8th edge.
// No backpressure on the serial side: bytes arriving while the FIFO is full are dropped (SSPRXOVR).
module ssp_receiver
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int DEPTH  = SSP_FIFO_DEPTH
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic              PSEL,
  input  logic              PWRITE,
  output logic [DATA_W-1:0] PRDATA,
  input  logic              SSPCLKIN,
  input  logic              SSPFSSIN,
  input  logic              SSPRXD,
  output logic              SSPRXINTR,
  output logic              RXEMPTY,
  output logic              SSPRXOVR
);
  localparam int CNT_W = $clog2(DATA_W);

  ssp_rx_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              clk_q, clk_d;
  logic              fe;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rx_byte;

  assign clk_d   = SSPCLKIN;
  assign fe      = clk_q && !SSPCLKIN;
  assign rx_byte = {shreg_q[DATA_W-2:0], SSPRXD};
  assign pop     = PSEL && !PWRITE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fe && SSPFSSIN) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (fe) begin
          shreg_d = rx_byte;
          cnt_d   = cnt_q + CNT_W'(1);
          // Frame sync is only meaningful alongside the last bit: it chains the next frame.
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = SSPFSSIN ? SHIFT : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      clk_q   <= clk_d;
    end
  end

  ssp_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .clear   (CLEAR),
    .push    (push),
    .pop     (pop),
    .din     (rx_byte),
    .dout    (PRDATA),
    .full    (SSPRXINTR),
    .empty   (RXEMPTY),
    .overrun (SSPRXOVR)
  );
endmodule
